// File: rtl/countdown_timer_bcd_if.sv
// Keypad/control and display/status bundle for countdown_timer_bcd.
// master = keypad/controller side, slave = timer side.
interface countdown_timer_bcd_if #(
  parameter int MIN_DIGITS = 1
);
  logic [3:0]              digit;
  logic                    digit_valid;
  logic                    start;
  logic                    pause;
  logic                    cancel;
  logic                    en;
  logic [3:0]              sec_ones;
  logic [3:0]              sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic                    zero;
  logic                    running;
  logic                    done;

  modport master (
    output digit, digit_valid, start, pause, cancel, en,
    input  sec_ones, sec_tens, mins, zero, running, done
  );

  modport slave (
    input  digit, digit_valid, start, pause, cancel, en,
    output sec_ones, sec_tens, mins, zero, running, done
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// BCD mm:ss countdown timer with keypad shift-entry, start/pause/resume/cancel,
// quick-start/extend by QUICK_SECS and a one-cycle done pulse.
module countdown_timer_bcd #(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 1,
  parameter int QUICK_SECS = 30
) (
  input logic             clock,
  input logic             clr,
  countdown_timer_bcd_if.slave bus
);
  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] QUICK_TENS = 4'(QUICK_SECS / 10);
  localparam logic [3:0] QUICK_ONES = 4'(QUICK_SECS % 10);
  localparam logic [7:0] QUICK_BIN  = 8'(QUICK_SECS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    sec_ones_reg, sec_ones_next;
  logic [3:0]    sec_tens_reg, sec_tens_next;
  logic [MW-1:0] mins_reg, mins_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          done_reg, done_next;
  logic          running_reg, running_next;

  // Per-digit minute helpers: borrow/carry ripple from the least-significant digit.
  logic [MIN_DIGITS:0] mins_zero_chain;
  logic [MIN_DIGITS:0] mins_nine_chain;
  logic [MW-1:0]       mins_dec;
  logic [MW-1:0]       mins_inc;
  logic [MW-1:0]       mins_shift;

  assign mins_zero_chain[0] = 1'b1;
  assign mins_nine_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < MIN_DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur = mins_reg[4*gi +: 4];
      assign mins_zero_chain[gi+1] = mins_zero_chain[gi] & (cur == 4'd0);
      assign mins_nine_chain[gi+1] = mins_nine_chain[gi] & (cur == 4'd9);
      assign mins_dec[4*gi +: 4] = !mins_zero_chain[gi] ? cur :
                                   (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      assign mins_inc[4*gi +: 4] = !mins_nine_chain[gi] ? cur :
                                   (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      if (gi == 0) begin : g_low
        assign mins_shift[3:0] = sec_tens_reg;
      end else begin : g_up
        assign mins_shift[4*gi +: 4] = mins_reg[4*(gi-1) +: 4];
      end
    end
  endgenerate

  logic mins_zero;
  logic zero_now;
  assign mins_zero = mins_zero_chain[MIN_DIGITS];
  assign zero_now  = (sec_ones_reg == 4'd0) && (sec_tens_reg == 4'd0) && mins_zero;

  // Extend works in binary on the seconds field; entries up to 99 keep the
  // result at most 98 after a single 60-second wrap.
  logic [7:0] secs_bin;
  logic [7:0] ext_sum;
  logic [7:0] ext_secs;
  logic       ext_carry;
  logic       ext_blocked;
  logic [3:0] ext_tens;
  logic [3:0] ext_ones;

  assign secs_bin    = ({4'd0, sec_tens_reg} * 8'd10) + {4'd0, sec_ones_reg};
  assign ext_sum     = secs_bin + QUICK_BIN;
  assign ext_carry   = (ext_sum >= 8'd60);
  assign ext_secs    = ext_carry ? (ext_sum - 8'd60) : ext_sum;
  assign ext_tens    = 4'(ext_secs / 8'd10);
  assign ext_ones    = 4'(ext_secs % 8'd10);
  assign ext_blocked = ext_carry & mins_nine_chain[MIN_DIGITS];

  logic tick_due;
  assign tick_due = (presc_reg == PRESC_LAST);

  always_comb begin
    state_next    = state_reg;
    sec_ones_next = sec_ones_reg;
    sec_tens_next = sec_tens_reg;
    mins_next     = mins_reg;
    presc_next    = presc_reg;
    done_next     = 1'b0;

    if (bus.cancel) begin
      state_next    = ST_IDLE;
      sec_ones_next = 4'd0;
      sec_tens_next = 4'd0;
      mins_next     = '0;
      presc_next    = '0;
    end else if (bus.start) begin
      case (state_reg)
        ST_IDLE: begin
          if (zero_now) begin
            sec_tens_next = QUICK_TENS;
            sec_ones_next = QUICK_ONES;
          end
          state_next = ST_RUN;
          presc_next = '0;
        end
        ST_PAUSE: begin
          state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!ext_blocked) begin
            sec_tens_next = ext_tens;
            sec_ones_next = ext_ones;
            if (ext_carry) begin
              mins_next = mins_inc;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else if (bus.pause && (state_reg == ST_RUN)) begin
      state_next = ST_PAUSE;
    end else if (bus.digit_valid && (state_reg == ST_IDLE) && (bus.digit <= 4'd9)) begin
      mins_next     = mins_shift;
      sec_tens_next = sec_ones_reg;
      sec_ones_next = bus.digit;
    end else if ((state_reg == ST_RUN) && bus.en) begin
      if (tick_due) begin
        presc_next = '0;
        if (sec_ones_reg != 4'd0) begin
          sec_ones_next = sec_ones_reg - 4'd1;
          // Only a 0:01 -> 0:00 step can land on zero.
          if ((sec_ones_reg == 4'd1) && (sec_tens_reg == 4'd0) && mins_zero) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else if (sec_tens_reg != 4'd0) begin
          sec_tens_next = sec_tens_reg - 4'd1;
          sec_ones_next = 4'd9;
        end else if (!mins_zero) begin
          mins_next     = mins_dec;
          sec_tens_next = 4'd5;
          sec_ones_next = 4'd9;
        end
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end
  end

  assign running_next = (state_next == ST_RUN);

  always_ff @(posedge clock) begin
    if (clr) begin
      state_reg    <= ST_IDLE;
      sec_ones_reg <= 4'd0;
      sec_tens_reg <= 4'd0;
      mins_reg     <= '0;
      presc_reg    <= '0;
      done_reg     <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sec_ones_reg <= sec_ones_next;
      sec_tens_reg <= sec_tens_next;
      mins_reg     <= mins_next;
      presc_reg    <= presc_next;
      done_reg     <= done_next;
      running_reg  <= running_next;
    end
  end

  assign bus.sec_ones = sec_ones_reg;
  assign bus.sec_tens = sec_tens_reg;
  assign bus.mins     = mins_reg;
  assign bus.zero     = zero_now;
  assign bus.running  = running_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench: three timer instances (1-digit/div1, 1-digit/div4, 2-digit/div1)
// sharing clock and clr, each driven through its own interface.
module tb_countdown_timer_bcd;
  logic clock;
  logic clr;
  int   checks;
  int   errors;

  countdown_timer_bcd_if #(.MIN_DIGITS(1)) if_a ();
  countdown_timer_bcd_if #(.MIN_DIGITS(1)) if_b ();
  countdown_timer_bcd_if #(.MIN_DIGITS(2)) if_c ();

  countdown_timer_bcd #(.MIN_DIGITS(1), .TICK_DIV(1), .QUICK_SECS(30))
    u_a (.clock(clock), .clr(clr), .bus(if_a));
  countdown_timer_bcd #(.MIN_DIGITS(1), .TICK_DIV(4), .QUICK_SECS(30))
    u_b (.clock(clock), .clr(clr), .bus(if_b));
  countdown_timer_bcd #(.MIN_DIGITS(2), .TICK_DIV(1), .QUICK_SECS(30))
    u_c (.clock(clock), .clr(clr), .bus(if_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic key_a(input logic [3:0] d);
    if_a.digit = d; if_a.digit_valid = 1'b1; step(1); if_a.digit_valid = 1'b0;
  endtask
  task automatic key_b(input logic [3:0] d);
    if_b.digit = d; if_b.digit_valid = 1'b1; step(1); if_b.digit_valid = 1'b0;
  endtask
  task automatic key_c(input logic [3:0] d);
    if_c.digit = d; if_c.digit_valid = 1'b1; step(1); if_c.digit_valid = 1'b0;
  endtask
  task automatic start_a();
    if_a.start = 1'b1; step(1); if_a.start = 1'b0;
  endtask
  task automatic start_b();
    if_b.start = 1'b1; step(1); if_b.start = 1'b0;
  endtask
  task automatic start_c();
    if_c.start = 1'b1; step(1); if_c.start = 1'b0;
  endtask
  task automatic cancel_a();
    if_a.cancel = 1'b1; step(1); if_a.cancel = 1'b0;
  endtask
  task automatic cancel_c();
    if_c.cancel = 1'b1; step(1); if_c.cancel = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; step(1); clr = 1'b0;
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.zero, if_a.running, if_a.done} !== 15'b000000000000_100) begin
      errors++; $display("FAIL reset_a value=%h z/r/d=%b%b%b expected 000 100",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.zero, if_a.running, if_a.done);
    end
    checks++;
    if ({if_c.mins, if_c.sec_tens, if_c.sec_ones, if_c.zero, if_c.running} !== 18'b0000000000000000_10) begin
      errors++; $display("FAIL reset_c value=%h z/r=%b%b expected 0000 10",
        {if_c.mins, if_c.sec_tens, if_c.sec_ones}, if_c.zero, if_c.running);
    end
    $display("test_reset done");
  endtask

  task automatic test_countdown();
    key_a(4'd1); key_a(4'd9); key_a(4'd9);
    start_a();
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running} !== {12'h199, 1'b1}) begin
      errors++; $display("FAIL cd_start value=%h running=%b expected 199 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running);
    end
    step(1);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h198) begin
      errors++; $display("FAIL cd_tick1 value=%h expected 198", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    step(98);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h100) begin
      errors++; $display("FAIL cd_tick99 value=%h expected 100", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    step(1);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h059) begin
      errors++; $display("FAIL cd_tick100 value=%h expected 059", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    step(58);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.done, if_a.running} !== {12'h001, 2'b01}) begin
      errors++; $display("FAIL cd_tick158 value=%h done=%b running=%b expected 001 0 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.done, if_a.running);
    end
    step(1);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.done, if_a.running, if_a.zero} !== {12'h000, 3'b101}) begin
      errors++; $display("FAIL cd_tick159 value=%h d/r/z=%b%b%b expected 000 101",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.done, if_a.running, if_a.zero);
    end
    step(1);
    checks++;
    if (if_a.done !== 1'b0) begin
      errors++; $display("FAIL cd_done_width done=%b expected 0", if_a.done);
    end
    $display("test_countdown done");
  endtask

  task automatic test_quick_start();
    start_a();
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running} !== {12'h030, 1'b1}) begin
      errors++; $display("FAIL quick_load_a value=%h running=%b expected 030 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running);
    end
    step(29);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.done} !== {12'h001, 1'b0}) begin
      errors++; $display("FAIL quick_29_a value=%h done=%b expected 001 0",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.done);
    end
    step(1);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.done} !== {12'h000, 1'b1}) begin
      errors++; $display("FAIL quick_30_a value=%h done=%b expected 000 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.done);
    end
    start_b();
    checks++;
    if ({if_b.mins, if_b.sec_tens, if_b.sec_ones, if_b.running} !== {12'h030, 1'b1}) begin
      errors++; $display("FAIL quick_load_b value=%h running=%b expected 030 1",
        {if_b.mins, if_b.sec_tens, if_b.sec_ones}, if_b.running);
    end
    step(119);
    checks++;
    if ({if_b.mins, if_b.sec_tens, if_b.sec_ones, if_b.done} !== {12'h001, 1'b0}) begin
      errors++; $display("FAIL quick_119_b value=%h done=%b expected 001 0",
        {if_b.mins, if_b.sec_tens, if_b.sec_ones}, if_b.done);
    end
    step(1);
    checks++;
    if ({if_b.mins, if_b.sec_tens, if_b.sec_ones, if_b.done, if_b.running} !== {12'h000, 2'b10}) begin
      errors++; $display("FAIL quick_120_b value=%h done=%b running=%b expected 000 1 0",
        {if_b.mins, if_b.sec_tens, if_b.sec_ones}, if_b.done, if_b.running);
    end
    $display("test_quick_start done");
  endtask

  task automatic test_pause_enable();
    start_a();
    step(5);
    if_a.pause = 1'b1; step(1); if_a.pause = 1'b0;
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running} !== {12'h025, 1'b0}) begin
      errors++; $display("FAIL pause_enter value=%h running=%b expected 025 0",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running);
    end
    step(20);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h025) begin
      errors++; $display("FAIL pause_hold value=%h expected 025", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    start_a();
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running} !== {12'h025, 1'b1}) begin
      errors++; $display("FAIL resume value=%h running=%b expected 025 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running);
    end
    step(1);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h024) begin
      errors++; $display("FAIL resume_tick value=%h expected 024", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    if_a.en = 1'b0;
    step(10);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running} !== {12'h024, 1'b1}) begin
      errors++; $display("FAIL en_freeze value=%h running=%b expected 024 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running);
    end
    if_a.en = 1'b1;
    cancel_a();
    step(1);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running, if_a.done} !== {12'h000, 2'b00}) begin
      errors++; $display("FAIL cancel_run value=%h running=%b done=%b expected 000 0 0",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running, if_a.done);
    end
    $display("test_pause_enable done");
  endtask

  task automatic test_extend();
    if_a.en = 1'b0;
    key_a(4'd4); key_a(4'd5);
    start_a(); start_a();
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h115) begin
      errors++; $display("FAIL extend_45 value=%h expected 115", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    cancel_a();
    key_a(4'd9); key_a(4'd9);
    start_a(); start_a();
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h169) begin
      errors++; $display("FAIL extend_99 value=%h expected 169", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    cancel_a();
    key_a(4'd9); key_a(4'd5); key_a(4'd0);
    start_a(); start_a();
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones, if_a.running} !== {12'h950, 1'b1}) begin
      errors++; $display("FAIL extend_ovf value=%h running=%b expected 950 1",
        {if_a.mins, if_a.sec_tens, if_a.sec_ones}, if_a.running);
    end
    key_a(4'd3);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h950) begin
      errors++; $display("FAIL digit_in_run value=%h expected 950", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    cancel_a();
    if_a.en = 1'b1;
    $display("test_extend done");
  endtask

  task automatic test_entry();
    key_a(4'd1); key_a(4'd2); key_a(4'd3); key_a(4'd4);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h234) begin
      errors++; $display("FAIL entry_1dig value=%h expected 234", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    key_a(4'hA);
    checks++;
    if ({if_a.mins, if_a.sec_tens, if_a.sec_ones} !== 12'h234) begin
      errors++; $display("FAIL entry_bad_digit value=%h expected 234", {if_a.mins, if_a.sec_tens, if_a.sec_ones});
    end
    key_c(4'd1); key_c(4'd2); key_c(4'd3); key_c(4'd4);
    checks++;
    if ({if_c.mins, if_c.sec_tens, if_c.sec_ones} !== 16'h1234) begin
      errors++; $display("FAIL entry_2dig value=%h expected 1234", {if_c.mins, if_c.sec_tens, if_c.sec_ones});
    end
    cancel_c();
    key_c(4'd1); key_c(4'd0); key_c(4'd0); key_c(4'd0);
    start_c();
    step(1);
    checks++;
    if ({if_c.mins, if_c.sec_tens, if_c.sec_ones} !== 16'h0959) begin
      errors++; $display("FAIL borrow_2dig value=%h expected 0959", {if_c.mins, if_c.sec_tens, if_c.sec_ones});
    end
    cancel_c();
    cancel_a();
    $display("test_entry done");
  endtask

  task automatic test_back_to_back();
    key_b(4'd1); key_b(4'd7);
    start_b();
    step(2);
    checks++;
    if ({if_b.mins, if_b.sec_tens, if_b.sec_ones, if_b.running} !== {12'h017, 1'b1}) begin
      errors++; $display("FAIL clr_pre value=%h running=%b expected 017 1",
        {if_b.mins, if_b.sec_tens, if_b.sec_ones}, if_b.running);
    end
    clr = 1'b1; step(1); clr = 1'b0;
    checks++;
    if ({if_b.mins, if_b.sec_tens, if_b.sec_ones, if_b.running, if_b.zero} !== {12'h000, 2'b01}) begin
      errors++; $display("FAIL clr_mid value=%h running=%b zero=%b expected 000 0 1",
        {if_b.mins, if_b.sec_tens, if_b.sec_ones}, if_b.running, if_b.zero);
    end
    step(1);
    checks++;
    if (if_b.done !== 1'b0) begin
      errors++; $display("FAIL clr_no_done done=%b expected 0", if_b.done);
    end
    key_b(4'd1); key_b(4'd7);
    start_b();
    step(3);
    if_b.cancel = 1'b1; if_b.start = 1'b1;
    step(1);
    if_b.cancel = 1'b0; if_b.start = 1'b0;
    checks++;
    if ({if_b.mins, if_b.sec_tens, if_b.sec_ones, if_b.running} !== {12'h000, 1'b0}) begin
      errors++; $display("FAIL cancel_start value=%h running=%b expected 000 0",
        {if_b.mins, if_b.sec_tens, if_b.sec_ones}, if_b.running);
    end
    step(1);
    checks++;
    if ({if_b.done, if_b.running} !== 2'b00) begin
      errors++; $display("FAIL cancel_no_done done=%b running=%b expected 0 0", if_b.done, if_b.running);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1;
    if_a.digit = 4'd0; if_a.digit_valid = 1'b0; if_a.start = 1'b0;
    if_a.pause = 1'b0; if_a.cancel = 1'b0; if_a.en = 1'b1;
    if_b.digit = 4'd0; if_b.digit_valid = 1'b0; if_b.start = 1'b0;
    if_b.pause = 1'b0; if_b.cancel = 1'b0; if_b.en = 1'b1;
    if_c.digit = 4'd0; if_c.digit_valid = 1'b0; if_c.start = 1'b0;
    if_c.pause = 1'b0; if_c.cancel = 1'b0; if_c.en = 1'b1;
    step(2);
    test_reset();
    test_countdown();
    test_quick_start();
    test_pause_enable();
    test_extend();
    test_entry();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Parametrised successor to the single-minute-digit microwave countdown timer.
- Accepts keypad BCD digits by shift-entry and counts down mm:ss at a programmable tick rate.
- Adds start/pause/resume/cancel control, a +QUICK_SECS quick-start/extend, and a one-cycle done pulse.
- Sits between the keypad decoder and the display/magnetron control logic.

Parameters:
MIN_DIGITS, 1, number of BCD minute digits (1..2).
TICK_DIV, 1, enabled clock cycles per one-second tick (>=1).
QUICK_SECS, 30, seconds added by start when idle-at-zero or running (1..59).

Ports:
clock  in  1  system clock, rising edge.
clr  in  1  synchronous reset, active-high.
digit  in  4  BCD keypad value.
digit_valid  in  1  one-cycle strobe: shift digit in.
start  in  1  start / resume / quick-add strobe.
pause  in  1  pause strobe.
cancel  in  1  stop and clear strobe.
en  in  1  count enable (door closed); 0 freezes counting.
sec_ones  out  4  BCD seconds units.
sec_tens  out  4  BCD seconds tens (0..9; entries 60..99 allowed).
mins  out  4*MIN_DIGITS  BCD minutes, least-significant digit in [3:0].
zero  out  1  all digits 0 (combinational from registers).
running  out  1  state==RUN.
done  out  1  one-cycle pulse when countdown reaches 0.

Behaviour:
- Reset is synchronous, active-high, one clock only: on clr, all digits 0, state IDLE, prescaler 0, running 0, done 0 (so zero=1).
- States: IDLE, RUN, PAUSE.
- Per-cycle priority: clr > cancel > start > pause > digit_valid > tick.
- Digit entry (IDLE only, digit<=9):
  - mins shifts up one digit and mins[3:0] <- sec_tens.
  - sec_tens <- sec_ones; sec_ones <- digit.
  - The top minute digit is discarded.
  - digit>9, or digit_valid in RUN/PAUSE, is ignored.
- start in IDLE:
  - If zero=1, load 0:QUICK_SECS (tens=Q/10, ones=Q%10).
  - Then go to RUN and clear the prescaler.
- start in PAUSE: go to RUN; prescaler keeps its value.
- start in RUN (extend):
  - S = 10*sec_tens + sec_ones; sum = S + QUICK_SECS.
  - If sum >= 60: sum -= 60 and minutes += 1 (BCD carry).
  - If the minutes would overflow (all 9s), the request is ignored.
  - Prescaler does not advance in that cycle; tick is deferred.
- pause: in RUN go to PAUSE; ignored in IDLE and PAUSE.
- cancel: any state -> IDLE, all digits 0, prescaler 0.
- Prescaler:
  - Advances only when state==RUN and en=1.
  - Produces a tick and returns to 0 when count==TICK_DIV-1.
  - With TICK_DIV=1, every enabled RUN cycle ticks.
- Tick decrement (BCD with borrow):
  - sec_ones>0: ones-1.
  - Else if sec_tens>0: tens-1, ones=9.
  - Else if mins>0: mins-1 with BCD borrow across minute digits, tens=5, ones=9.
  - Entered seconds 60..99 count down naturally, e.g. 1:99 -> 1:98 ... 1:00 -> 0:59.
- Completion:
  - The tick that produces 0:00 also moves the state to IDLE.
  - done=1 in the following cycle only.
  - running drops with the state change.
- RUN entered with value already 0 is not possible: start at zero loads QUICK_SECS.
- en=0 in RUN: digits and prescaler frozen, running stays 1.
- clr or cancel mid-run: no done pulse.
- Outputs are registered except zero.

Test Plan:
1. TICK_DIV=1, MIN_DIGITS=1: enter 1,9,9 and start -> 1:98 after 1 tick, 1:00 after 99, 0:59 after 100, 0:00 after 159; done high exactly 1 cycle; state IDLE; zero=1.
2. start with display 0:00 -> 0:30 loaded, running=1; done after 30 ticks; TICK_DIV=4 -> done after 120 enabled cycles.
3. Pause and en:
   - Run 5 ticks from 0:30, pause, hold 20 cycles -> 0:25 unchanged.
   - start resumes and reaches 0:24 after 1 tick.
   - en=0 for 10 cycles freezes the value and running stays 1.
4. Extend:
   - Running at 0:45, start -> 1:15.
   - At 0:99, start -> 1:69.
   - At 9:50 (MIN_DIGITS=1), start -> ignored, stays 9:50.
5. Entry:
   - Digits 1,2,3,4 with MIN_DIGITS=1 -> 2:34; with MIN_DIGITS=2 -> 12:34.
   - digit 0xA is ignored.
   - digit_valid during RUN is ignored.
6. Reset/cancel mid-run with TICK_DIV=4 at 0:17:
   - clr -> 0:00, IDLE, no done next cycle.
   - cancel and start in the same cycle -> cancel wins, IDLE.
